// File: rtl/mdma_ram_ecc_pkg.sv
// mdma_ram_ecc_pkg: SECDED codeword layout, encoder and RAM FSM states for the 80b x 512 DMA RAM.
// Codeword = {overall parity, 7 Hamming check bits, 80 data bits}.
package mdma_ram_ecc_pkg;

    localparam int DATA_W = 80;
    localparam int HW     = 7;
    localparam int ECC_W  = 8;
    localparam int CW_W   = DATA_W + ECC_W;

    typedef logic [CW_W-1:0] mdma_cw_t;

    typedef enum logic {INIT, READY} mdma_ram_st_e;

    // Parity-check column of data bit i: its Hamming position, skipping powers of two.
    function automatic logic [HW-1:0] h_col(input int i);
        logic [HW-1:0] r;
        int n;
        r = '0;
        n = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == i) r = HW'(p);
                n++;
            end
        end
        return r;
    endfunction

    function automatic mdma_cw_t ecc_enc(input logic [DATA_W-1:0] d);
        logic [HW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++)
            if (d[i]) c ^= h_col(i);
        return {^{c, d}, c, d};
    endfunction

endpackage

// File: rtl/mdma_secded_80b_dec.sv
// mdma_secded_80b_dec: combinational SECDED decode of an 88b codeword into corrected data and error flags.
module mdma_secded_80b_dec
    import mdma_ram_ecc_pkg::*;
(
    input  mdma_cw_t            cw_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                sbe_o,
    output logic                dbe_o
);

    logic [HW-1:0] syn;

    always_comb begin
        syn = cw_i[DATA_W +: HW];
        for (int i = 0; i < DATA_W; i++)
            if (cw_i[i]) syn ^= h_col(i);
        sbe_o  = ^cw_i;
        dbe_o  = !sbe_o && syn != '0;
        data_o = cw_i[DATA_W-1:0];
        for (int i = 0; i < DATA_W; i++)
            data_o[i] = data_o[i] ^ (sbe_o && syn == h_col(i));
    end

endmodule

// File: rtl/mdma_80bx512_ram_resp.sv
// mdma_80bx512_ram_resp: self-initialising 512x80 SECDED-protected RAM responder with pipelined reads.
// Define MDMA_RAM_ERR_INJ_EN to add the inj_sbe/inj_dbe write-corruption ports.
module mdma_80bx512_ram_resp
    import mdma_ram_ecc_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int AW     = $clog2(DEPTH),
    parameter int DW     = DATA_W,
    parameter int RD_LAT = 2
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] wadr,
    input  logic          wen,
    input  logic [DW-1:0] wdat,
    input  logic          ren,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdat,
    output logic          rsbe,
    output logic          rdbe,
    output logic          init_done
`ifdef MDMA_RAM_ERR_INJ_EN
   ,input  logic          inj_sbe,
    input  logic          inj_dbe
`endif
);

    mdma_ram_st_e  st_q;
    logic [AW-1:0] init_ptr_q;
    logic          init_done_q;
    mdma_cw_t      mem_q [DEPTH];
    mdma_cw_t      rd_cw_q;
    logic          rd_v_q;
    logic [DW-1:0] rdat_q;
    logic          rsbe_q, rdbe_q;
    logic [DW-1:0] dec_data;
    logic          dec_sbe, dec_dbe;
    logic          ready, wr_en;
    logic [AW-1:0] wr_adr;
    mdma_cw_t      wr_cw, inj_mask;

`ifdef MDMA_RAM_ERR_INJ_EN
    assign inj_mask = inj_dbe ? mdma_cw_t'(3) : mdma_cw_t'(inj_sbe);
`else
    assign inj_mask = '0;
`endif

    assign ready  = st_q == READY;
    assign wr_en  = !ready || wen;
    assign wr_adr = ready ? wadr : init_ptr_q;
    assign wr_cw  = ready ? ecc_enc(wdat) ^ inj_mask : ecc_enc('0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
        end else if (st_q == INIT) begin
            init_ptr_q <= init_ptr_q + 1'b1;
            if (init_ptr_q == AW'(DEPTH - 1)) begin
                st_q        <= READY;
                init_done_q <= 1'b1;
            end
        end
    end

    // Array is deliberately unreset; the INIT sweep provides known contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_adr] <= wr_cw;
        if (ren && ready) rd_cw_q <= mem_q[radr];
    end

    mdma_secded_80b_dec u_dec (
        .cw_i   (rd_cw_q),
        .data_o (dec_data),
        .sbe_o  (dec_sbe),
        .dbe_o  (dec_dbe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v_q <= 1'b0;
            rdat_q <= '0;
            rsbe_q <= 1'b0;
            rdbe_q <= 1'b0;
        end else begin
            rd_v_q <= ren && ready;
            rdat_q <= rd_v_q ? dec_data : rdat_q;
            rsbe_q <= rd_v_q && dec_sbe;
            rdbe_q <= rd_v_q && dec_dbe;
        end
    end

    // RD_LAT==1 bypasses the output register; rdat_q then only serves as the hold value.
    assign rdat      = (RD_LAT == 1 && rd_v_q) ? dec_data : rdat_q;
    assign rsbe      = RD_LAT == 1 ? rd_v_q && dec_sbe : rsbe_q;
    assign rdbe      = RD_LAT == 1 ? rd_v_q && dec_dbe : rdbe_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_mdma_80bx512_ram_resp.sv
// tb_mdma_80bx512_ram_resp: randomized self-checking bench against a queue/array reference of the RAM responder.
// Injection scenarios run only when MDMA_RAM_ERR_INJ_EN is defined.
module tb_mdma_80bx512_ram_resp;

    localparam int DEPTH  = 512;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  wadr = '0, radr = '0;
    logic        wen = 1'b0, ren = 1'b0;
    logic [79:0] wdat = '0;
    logic [79:0] rdat;
    logic        rsbe, rdbe, init_done;
    logic        inj_sbe = 1'b0, inj_dbe = 1'b0;

    always #5 clk = ~clk;

    mdma_80bx512_ram_resp #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wadr      (wadr),
        .wen       (wen),
        .wdat      (wdat),
        .ren       (ren),
        .radr      (radr),
        .rdat      (rdat),
        .rsbe      (rsbe),
        .rdbe      (rdbe),
        .init_done (init_done)
`ifdef MDMA_RAM_ERR_INJ_EN
       ,.inj_sbe   (inj_sbe),
        .inj_dbe   (inj_dbe)
`endif
    );

    typedef struct {
        int          due;
        logic [79:0] d;
        bit          sbe;
        bit          dbe;
    } exp_t;

    int          n_chk = 0, n_fail = 0, t = 0;
    exp_t        exp_q[$];
    logic [79:0] mdat [DEPTH];
    int          merr [DEPTH];
    logic [79:0] last = '0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] rnd();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[79:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mdat[i] = '0;
            merr[i] = 0;
        end
        exp_q.delete();
        last = '0;
    endtask

    // One clock: apply a write and/or read, advance, then compare outputs at the falling edge.
    task automatic op(input bit we, input logic [8:0] wa, input logic [79:0] wd,
                      input bit re, input logic [8:0] ra, input bit sb = 0, input bit db = 0);
        exp_t e;
        if (re) begin
            e.due = t + RD_LAT;
            e.d   = merr[ra] == 2 ? mdat[ra] ^ 80'h3 : mdat[ra];
            e.sbe = merr[ra] == 1;
            e.dbe = merr[ra] == 2;
            exp_q.push_back(e);
        end
        if (we) begin
            mdat[wa] = wd;
            merr[wa] = db ? 2 : sb ? 1 : 0;
        end
        wen = we; wadr = wa; wdat = wd; ren = re; radr = ra; inj_sbe = sb; inj_dbe = db;
        @(posedge clk);
        @(negedge clk);
        t++;
        wen = 1'b0; ren = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0;
        if (exp_q.size() != 0 && exp_q[0].due == t) begin
            e = exp_q.pop_front();
            check("rd_data", rdat, e.d);
            check("rd_sbe", 80'(rsbe), 80'(e.sbe));
            check("rd_dbe", 80'(rdbe), 80'(e.dbe));
            last = e.d;
        end else begin
            check("hold_data", rdat, last);
            check("idle_sbe", 80'(rsbe), 80'(0));
            check("idle_dbe", 80'(rdbe), 80'(0));
        end
    endtask

    // Release reset, hammer wen/ren during the sweep, and time init_done.
    task automatic release_and_init();
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < DEPTH + 8) begin
            wen = 1'(($urandom() & 1)); wadr = 9'($urandom()); wdat = rnd();
            ren = 1'(($urandom() & 1)); radr = 9'($urandom());
            @(posedge clk);
            #1;
            n++;
            if (!init_done) begin
                check("init_rdat", rdat, '0);
                check("init_flags", 80'({rsbe, rdbe}), 80'(0));
            end
        end
        wen = 1'b0; ren = 1'b0;
        check("init_cycles", 80'(n), 80'(DEPTH));
        model_clear();
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdat", rdat, '0);
        check("rst_flags", 80'({rsbe, rdbe}), 80'(0));
        check("rst_init_done", 80'(init_done), 80'(0));
        release_and_init();

        op(1, 9'h1FF, 80'h1234_5678_9ABC_DEF0_1357, 0, 0);
        op(0, 0, 0, 1, 9'h1FF);
        repeat (3) op(0, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) op(1, 9'(i), {10{8'(i) ^ 8'h5A}}, 0, 0);
        for (int i = 0; i < 16; i++) op(0, 0, 0, 1, 9'(i));
        repeat (3) op(0, 0, 0, 0, 0);

        op(1, 9'h010, 80'hAAAA_0000_1111_2222_3333, 0, 0);
        op(1, 9'h010, 80'hBBBB_4444_5555_6666_7777, 1, 9'h010);
        op(0, 0, 0, 1, 9'h010);
        repeat (3) op(0, 0, 0, 0, 0);

`ifdef MDMA_RAM_ERR_INJ_EN
        op(1, 9'h020, 80'hDEAD_BEEF_CAFE_F00D_0042, 0, 0, 1, 0);
        op(0, 0, 0, 1, 9'h020);
        repeat (3) op(0, 0, 0, 0, 0);
        op(1, 9'h020, 80'hDEAD_BEEF_CAFE_F00D_0043, 0, 0, 0, 1);
        op(0, 0, 0, 1, 9'h020);
        op(1, 9'h021, 80'h0F0F_0F0F_0F0F_0F0F_0F0F, 0, 0, 1, 1);
        op(0, 0, 0, 1, 9'h021);
        repeat (3) op(0, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 400; i++)
            op(1'($urandom() & 1), 9'($urandom_range(31, 0)), rnd(),
               1'($urandom() & 1), 9'($urandom_range(31, 0)));
        repeat (3) op(0, 0, 0, 0, 0);
        check("drain", 80'(exp_q.size()), 80'(0));

        op(0, 0, 0, 1, 9'h1FF);
        ren = 1'b1; radr = 9'h1FF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrd_rst_rdat", rdat, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrd_rst_rdat", rdat, '0);
            check("midrd_rst_flags", 80'({rsbe, rdbe}), 80'(0));
            check("midrd_rst_done", 80'(init_done), 80'(0));
        end
        ren = 1'b0;
        release_and_init();
        for (int i = 0; i < 3; i++) op(0, 0, 0, 0, 0);
        op(0, 0, 0, 1, 9'h1FF);
        op(0, 0, 0, 1, 9'h010);
        repeat (3) op(0, 0, 0, 0, 0);
        check("drain_end", 80'(exp_q.size()), 80'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
